// File: rtl/dmem_access_unit.sv
// dmem_access_unit: requester-side controller for the Data_Memory BRAM port.
// It takes one load or store at a time over a req/ready/done handshake and
// turns the 32-bit byte address into a word address. It drives the BRAM
// enable, write-enable, address and data lines from registers, and for loads
// it waits out the one-cycle BRAM read latency before returning the word.
module dmem_access_unit #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  input  logic [DATA_W-1:0] douta
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RD_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t state;
  logic   we_q;
  logic   err_q;
  logic   bad_addr;

  // A request is rejected if it is not word aligned or lies beyond the last word.
  assign bad_addr = (addr[1:0] != 2'b00) || (addr[31:ADDR_W+2] != '0);

  // Request sequencing; every output is a register updated here.
  // NOTE: sequential state uses non-blocking (<=) assignments so that all
  // registers update together at the edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      we_q  <= 1'b0;
      err_q <= 1'b0;
      ready <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
      ena   <= 1'b0;
      wea   <= 1'b0;
      addra <= '0;
      dina  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            we_q  <= we;
            ready <= 1'b0;
            if (bad_addr) begin
              // The BRAM is never touched. DONE is entered with done still low,
              // so the pulse lands one cycle after accept, as it does for stores.
              err_q <= 1'b1;
              state <= DONE;
            end else begin
              err_q <= 1'b0;
              addra <= addr[ADDR_W+1:2];
              dina  <= wdata;
              ena   <= 1'b1;
              wea   <= we;
              state <= ACCESS;
            end
          end
        end

        ACCESS: begin
          // The BRAM samples ena/wea/addra/dina at the edge that closes this cycle.
          ena <= 1'b0;
          wea <= 1'b0;
          if (we_q) begin
            done  <= 1'b1;
            err   <= 1'b0;
            state <= DONE;
          end else begin
            state <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          // douta carries the word read at the previous edge.
          rdata <= douta;
          done  <= 1'b1;
          err   <= 1'b0;
          state <= DONE;
        end

        DONE: begin
          if (done) begin
            done  <= 1'b0;
            err   <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            // Second DONE cycle on the error path: raise the pulse now.
            done <= 1'b1;
            err  <= err_q;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: randomized, scoreboard-checked bench for dmem_access_unit.
// A BRAM model with one-cycle read latency stands in for Data_Memory. A
// word-array reference model predicts each response when the request is
// issued, and a negedge monitor checks the DUT's memory-port activity and
// done pulses against the queued predictions.
module tb_dmem_access_unit;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              req   = 1'b0;
  logic              we    = 1'b0;
  logic [31:0]       addr  = '0;
  logic [DATA_W-1:0] wdata = '0;
  logic              ready, done, err, ena, wea;
  logic [DATA_W-1:0] rdata, dina;
  logic [DATA_W-1:0] douta = '0;
  logic [ADDR_W-1:0] addra;

  dmem_access_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .ready (ready),
    .done  (done),
    .err   (err),
    .rdata (rdata),
    .ena   (ena),
    .wea   (wea),
    .addra (addra),
    .dina  (dina),
    .douta (douta)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Data_Memory stand-in: read-first, one-cycle read latency.
  logic [DATA_W-1:0] bram [DEPTH];
  always @(posedge clk) begin
    if (ena) begin
      if (wea) bram[addra] <= dina;
      douta <= bram[addra];
    end
  end

  function automatic logic [31:0] init_word(input int i);
    return 32'h1000_0000 + i * 32'h0001_0003;
  endfunction

  // Reference model: plain word array plus the last successfully loaded value.
  typedef struct {
    bit          err;
    bit          we;
    int          word;
    logic [31:0] data;
    logic [31:0] rdata;
    int          acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] ref_rdata = '0;

  function automatic exp_t model(input bit w, input logic [31:0] a, input logic [31:0] d,
                                 input int c);
    exp_t e;
    e.err     = (a % 4 != 0) || (a >= 4 * DEPTH);
    e.we      = w;
    e.word    = int'((a / 4) % DEPTH);
    e.data    = d;
    e.acc_cyc = c;
    if (!e.err) begin
      if (w) ref_mem[e.word] = d;
      else   ref_rdata = ref_mem[e.word];
    end
    e.rdata = ref_rdata;
    return e;
  endfunction

  // Monitor: port activity and completions against the scoreboard.
  exp_t e_mon;
  bit   prev_done = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      check("ready_with_ena", ready && ena, 1'b0);
      if (!done) check("err_without_done", err, 1'b0);
      if (ena) begin
        if (sb_q.size() == 0) begin
          check("ena_unexpected", 1'b1, 1'b0);
        end else begin
          check("ena_on_bad_req", sb_q[0].err, 1'b0);
          check("ena_timing", cyc - sb_q[0].acc_cyc, 1);
          check("addra", addra, sb_q[0].word);
          check("wea", wea, sb_q[0].we);
          if (sb_q[0].we) check("dina", dina, sb_q[0].data);
        end
      end
      if (done) begin
        check("done_width", prev_done, 1'b0);
        if (sb_q.size() == 0) begin
          check("done_unexpected", 1'b1, 1'b0);
        end else begin
          e_mon = sb_q.pop_front();
          check("err", err, e_mon.err);
          check("rdata", rdata, e_mon.rdata);
          check("latency", cyc - e_mon.acc_cyc, (e_mon.err || e_mon.we) ? 2 : 3);
        end
      end
      prev_done = done;
    end
  end

  // Issue one request; call at a negedge. With hold=1, req stays high carrying
  // junk afterwards, which the DUT must ignore until the next issue.
  task automatic issue(input bit w, input logic [31:0] a, input logic [31:0] d, input bit hold);
    int waited = 0;
    while (ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (ready !== 1'b1) begin
      check("ready_timeout", ready, 1'b1);
      req = 1'b0;
      return;
    end
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = d;
    sb_q.push_back(model(w, a, d, cyc));
    @(negedge clk);
    if (hold) begin
      we    = $urandom;
      addr  = $urandom;
      wdata = $urandom;
    end else begin
      req = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t ab;
    int   waited;
    for (int i = 0; i < DEPTH; i++) begin
      bram[i]    = init_word(i);
      ref_mem[i] = init_word(i);
    end

    // Reset held with a request pending.
    rst_n = 1'b0;
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'h8;
    wdata = 32'h77;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_ena", ena, 1'b0);
    check("rst_wea", wea, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_addra", addra, 10'h0);
    check("rst_dina", dina, 32'h0);
    req = 1'b0;
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", ready, 1'b1);
    check("idle_ena", ena, 1'b0);

    // Store then load of word 2.
    issue(1'b1, 32'h8, 32'd32, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 1'b0);
    // Misaligned load, out-of-range store, then word 2 again.
    issue(1'b0, 32'h6, 32'h0, 1'b0);
    issue(1'b1, 32'h1000, 32'h99, 1'b0);
    issue(1'b0, 32'h8, 32'h0, 1'b0);
    // Last word, and word 0 unaffected.
    issue(1'b1, 32'hFFC, 32'hDEAD_BEEF, 1'b0);
    issue(1'b0, 32'hFFC, 32'h0, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 1'b0);

    // req held high continuously, alternating store/load.
    for (int i = 0; i < 10; i++)
      issue(i[0], 32'($urandom_range(0, 15)) * 4, $urandom, 1'b1);
    req = 1'b0;

    // Reset abort of a store while in ACCESS.
    waited = 0;
    while (ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("abort_ready", ready, 1'b1);
    req   = 1'b1;
    we    = 1'b1;
    addr  = 32'hC;
    wdata = 32'h55;
    ab.err = 1'b0; ab.we = 1'b1; ab.word = 3; ab.data = 32'h55;
    ab.rdata = ref_rdata; ab.acc_cyc = cyc;
    sb_q.push_back(ab);
    @(posedge clk);
    #2;
    check("abort_ena_high", ena, 1'b1);
    req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("abort_ena", ena, 1'b0);
    check("abort_wea", wea, 1'b0);
    check("abort_ready_rst", ready, 1'b1);
    check("abort_done", done, 1'b0);
    @(posedge clk);
    #3;
    sb_q.delete();
    ref_rdata = '0;
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, 32'hC, 32'h0, 1'b0);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int          cls;
      bit          hold;
      cls = $urandom_range(0, 7);
      if (cls <= 4)      a = 32'($urandom_range(0, 15)) * 4;
      else if (cls == 5) a = 32'($urandom_range(1020, 1023)) * 4;
      else if (cls == 6) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
      else               a = ($urandom | 32'h1000) & ~32'h3;
      hold = ($urandom_range(0, 1) == 1);
      if (req == 1'b0) repeat ($urandom_range(0, 2)) @(negedge clk);
      issue($urandom_range(0, 1) == 1, a, $urandom, hold);
    end
    req = 1'b0;

    repeat (8) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
